// File: rtl/serial_adder_nbit.sv
// Multi-cycle adder: BITS_PER_CYCLE bits per clock, LSB chunk first, start/ready + valid/ack.
// Optional two's-complement Overflow output enabled by defining SERIAL_ADDER_OVF_EN.
module serial_adder_nbit #(
    parameter int unsigned WIDTH          = 8,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Carry_in,
    input  logic             ack,
    output logic             ready,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] SUM,
`ifdef SERIAL_ADDER_OVF_EN
    output logic             Overflow,
`endif
    output logic             Carry_out
);

    localparam int unsigned NCHUNK = WIDTH / BITS_PER_CYCLE;
    localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    if ((WIDTH < 1) || (BITS_PER_CYCLE < 1) || ((WIDTH % BITS_PER_CYCLE) != 0)) begin : g_param_err
        $error("serial_adder_nbit: BITS_PER_CYCLE must be >= 1 and divide WIDTH exactly");
    end

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            state_q;
    logic [WIDTH-1:0]  a_q, b_q, sum_q;
    logic              carry_q, carry_out_q;
    logic              ready_q, busy_q, valid_q;
    logic [CntW-1:0]   cnt_q;

    logic [BITS_PER_CYCLE-1:0] chunk_a, chunk_b, chunk_sum;
    logic                      chunk_cout, chunk_cmsb;
    logic                      c, hs, hc;
    int unsigned               chunk_lsb;
    logic                      last_chunk;

    // Ripple chain of full adders, each made of two half adders.
    always_comb begin
        chunk_lsb  = 32'(cnt_q) * BITS_PER_CYCLE;
        chunk_a    = a_q[chunk_lsb +: BITS_PER_CYCLE];
        chunk_b    = b_q[chunk_lsb +: BITS_PER_CYCLE];
        chunk_sum  = '0;
        chunk_cmsb = 1'b0;
        hs         = 1'b0;
        hc         = 1'b0;
        c          = carry_q;
        for (int i = 0; i < int'(BITS_PER_CYCLE); i++) begin
            chunk_cmsb   = c;
            hs           = chunk_a[i] ^ chunk_b[i];
            hc           = chunk_a[i] & chunk_b[i];
            chunk_sum[i] = hs ^ c;
            c            = hc | (hs & c);
        end
        chunk_cout = c;
        last_chunk = (cnt_q == CntW'(NCHUNK - 1));
    end

`ifdef SERIAL_ADDER_OVF_EN
    logic ovf_q;
    assign Overflow = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            carry_out_q <= 1'b0;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        a_q     <= A;
                        b_q     <= B;
                        carry_q <= Carry_in;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    sum_q[chunk_lsb +: BITS_PER_CYCLE] <= chunk_sum;
                    carry_q <= chunk_cout;
                    if (last_chunk) begin
                        carry_out_q <= chunk_cout;
`ifdef SERIAL_ADDER_OVF_EN
                        // Carry into the MSB is the carry entering the last bit of the last chunk.
                        ovf_q       <= chunk_cmsb ^ chunk_cout;
`endif
                        busy_q      <= 1'b0;
                        valid_q     <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                StDone: begin
                    if (ack) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    ready_q <= 1'b1;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifndef SERIAL_ADDER_OVF_EN
    logic unused_cmsb;
    assign unused_cmsb = chunk_cmsb;
`endif

    assign ready     = ready_q;
    assign busy      = busy_q;
    assign valid     = valid_q;
    assign SUM       = sum_q;
    assign Carry_out = carry_out_q;

endmodule

// File: doc/serial_adder_nbit.md
Name: serial_adder_nbit

Overview:
- Parametrised multi-cycle adder. Adds two WIDTH-bit operands plus carry-in, BITS_PER_CYCLE bits per clock, LSB chunk first.
- Each chunk goes through a ripple chain of full adders built from half-adder pairs. Carry is held in a register between chunks.
- Trades latency for area in datapaths where a full-width ripple adder will not meet timing or is too large.
- Uses a start/ready and valid/ack handshake, so it can sit between sequencing FSMs.

Parameters:
- WIDTH, 8, operand and sum width in bits; must be >= 1.
- BITS_PER_CYCLE, 1, bits added per clock; must divide WIDTH exactly. NCHUNK = WIDTH/BITS_PER_CYCLE.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request an addition; honoured only when ready=1.
- A  input  WIDTH  operand A; sampled on the accepting edge.
- B  input  WIDTH  operand B; sampled on the accepting edge.
- Carry_in  input  1  carry into bit 0; sampled on the accepting edge.
- ack  input  1  consumer has taken the result; honoured only when valid=1.
- ready  output  1  block idle and able to accept start.
- busy  output  1  addition in progress.
- valid  output  1  SUM and Carry_out hold a completed result.
- SUM  output  WIDTH  result bits.
- Carry_out  output  1  carry out of bit WIDTH-1.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high on rst. All state changes happen on the rising edge of clk.
- Reset values: state=IDLE, ready=1, busy=0, valid=0, SUM=0, Carry_out=0; internal operand registers, carry register and chunk counter cleared.
- IDLE (ready=1):
  - start=1 latches A, B and Carry_in, clears chunk counter to 0, goes to RUN.
  - start=0 stays in IDLE.
- RUN (busy=1, ready=0):
  - Each edge adds chunk i (bits i*BPC to i*BPC+BPC-1) of the latched A and B plus the carry register.
  - Writes the chunk sum into SUM, updates the carry register and increments i.
  - Once chunk NCHUNK-1 is written: Carry_out takes the final carry, state goes to DONE.
  - start is ignored in RUN. A, B and Carry_in may change freely with no effect.
- DONE (valid=1):
  - SUM and Carry_out held stable.
  - ack=1 deasserts valid and returns to IDLE, so ready=1 on the following cycle.
  - start is ignored in DONE; back-to-back operation needs ack, then start.
- Latency: if start is accepted at edge 0, valid is high after edge NCHUNK and stays high until the ack edge. Minimum throughput is one result per NCHUNK+2 cycles.
- SUM during RUN holds partial results; it is only defined when valid=1.
- Arithmetic: unsigned, modulo 2^WIDTH, with Carry_out as bit WIDTH. Result equals {Carry_out,SUM} = A + B + Carry_in.
- Degenerate case BITS_PER_CYCLE=WIDTH: single RUN cycle, NCHUNK=1.
- rst asserted in any state, including mid-RUN or DONE: next state is IDLE with all reset values; any in-flight result is discarded.
- start and ack both high in DONE: ack honoured, start ignored.
- Parameter violation (WIDTH mod BITS_PER_CYCLE != 0): elaboration-time error via generate check.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port Overflow (1 bit), which indicates two's-complement overflow: carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - Captured on the same edge as Carry_out and held through DONE.
  - Reset value 0; cleared on reset.
- Undefined: no Overflow port and no overflow logic; all other behaviour identical.

Test Plan:
- Reset then idle check: rst=1 for 2 cycles -> ready=1, busy=0, valid=0, SUM=0, Carry_out=0.
- WIDTH=8, BPC=1: A=8'hFF, B=8'h01, Carry_in=0, start pulse -> busy=1 for 8 cycles; valid=1 exactly 8 edges after accept; SUM=8'h00, Carry_out=1; valid holds until ack, ready=1 the cycle after ack.
- WIDTH=8, BPC=4: A=8'h3C, B=8'h45, Carry_in=1 -> valid after 2 edges, SUM=8'h82, Carry_out=0. With SERIAL_ADDER_OVF_EN: Overflow=1.
- Busy-ignore: during RUN, pulse start and change A/B to 8'h00 -> result still SUM=8'h82/Carry_out=0 for the original operands; no second operation begins.
- Mid-operation reset: start A=8'hAA, B=8'h55, assert rst on 3rd RUN cycle -> next cycle ready=1, valid=0, SUM=0. A new start of A=8'h01, B=8'h01 then completes with SUM=8'h02.
- Randomised sweep: 1000 random A/B/Carry_in each for BPC in {1,2,8} -> {Carry_out,SUM} matches A+B+Carry_in, and valid latency always equals NCHUNK.
